kf_activity_monitor: RTL and testbench

Parametrised successor to the per-tile activity-metrics logic in the Kitten Fabric (FK33) tile. It observes up to N_CH spike handshake channels: the local core output plus the NoC ports. It keeps per-channel and total event counters and a busy-cycle counter, a windowed EMA activity level, a power hint and a transition-entropy estimate. An atomic snapshot/readout port feeds the HAL, adding read-and-clear semantics and simultaneous-event counting that a single-channel counter lacks.

---
 rtl/kf_activity_monitor_pkg.sv | 27 ++
 rtl/kf_activity_monitor_if.sv | 26 ++
 rtl/kf_activity_monitor_counter.sv | 43 ++++
 rtl/kf_activity_monitor.sv | 158 +++++++++++++++
 tb/tb_kf_activity_monitor.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kf_activity_monitor_pkg.sv
// Shared constants and types for the Kitten Fabric tile activity monitor.
// Channel indices follow the tile port order: local core first, then the
// four NoC ports. The read-select enum mirrors the shadow readout map for
// the default five-channel build.
package kf_activity_monitor_pkg;

  localparam int KF_ACT_CH_LOCAL = 0;
  localparam int KF_ACT_CH_NORTH = 1;
  localparam int KF_ACT_CH_SOUTH = 2;
  localparam int KF_ACT_CH_EAST  = 3;
  localparam int KF_ACT_CH_WEST  = 4;

  localparam int KF_ACT_N_CH_DEFAULT = 5;
  localparam int KF_DREAM_POWER_OVH  = 32;

  // Shadow readout map: channel counters, then total, then busy.
  typedef enum logic [2:0] {
    ACT_RD_CH_LOCAL = 3'd0,
    ACT_RD_CH_NORTH = 3'd1,
    ACT_RD_CH_SOUTH = 3'd2,
    ACT_RD_CH_EAST  = 3'd3,
    ACT_RD_CH_WEST  = 3'd4,
    ACT_RD_TOTAL    = 3'd5,
    ACT_RD_BUSY     = 3'd6
  } act_rd_sel_e;

endpackage

// File: rtl/kf_activity_monitor_if.sv
// Observed spike handshakes plus the snapshot/readout port of the activity
// monitor. The master side is the fabric/HAL, the slave side the monitor.
interface kf_activity_monitor_if #(
  parameter int N_CH  = 5,
  parameter int CNT_W = 32
);
  localparam int AW = $clog2(N_CH + 2);

  logic [N_CH-1:0]  ev_valid;
  logic [N_CH-1:0]  ev_ready;
  logic             snap_req;
  logic             snap_valid;
  logic [AW-1:0]    rd_addr;
  logic [CNT_W-1:0] rd_data;

  modport master (
    output ev_valid, ev_ready, snap_req, rd_addr,
    input  snap_valid, rd_data
  );

  modport slave (
    input  ev_valid, ev_ready, snap_req, rd_addr,
    output snap_valid, rd_data
  );

endinterface

// File: rtl/kf_activity_monitor_counter.sv
// kf_event_counter: one live event counter of the activity monitor.
// clr_load restarts the count at the same-cycle increment so no event is
// dropped by a clear. Macro KF_ACT_MON_SAT_EN selects saturation at
// all-ones instead of modulo wrap; a multi-event increment clamps.
module kf_event_counter #(
  parameter int W     = 32,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [INC_W-1:0] inc,
  input  logic             clr_load,
  output logic [W-1:0]     cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  function automatic logic [W-1:0] add_cnt(input logic [W-1:0] base,
                                           input logic [INC_W-1:0] step);
`ifdef KF_ACT_MON_SAT_EN
    logic [W+INC_W:0] sum;
    sum = {{(INC_W+1){1'b0}}, base} + {{(W+1){1'b0}}, step};
    return (|sum[W+INC_W:W]) ? {W{1'b1}} : sum[W-1:0];
`else
    return base + W'(step);
`endif
  endfunction

  // Next count: restart from the increment on clear, otherwise accumulate.
  always_comb begin
    cnt_d = clr_load ? add_cnt('0, inc) : add_cnt(cnt_q, inc);
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/kf_activity_monitor.sv
// kf_activity_monitor: per-tile spike activity metrics. Counts handshakes
// per channel and in total, counts busy cycles, tracks a windowed EMA of the
// event rate, derives a power hint and a transition-entropy estimate, and
// exposes an atomic shadow snapshot with read-and-clear. Macro
// KF_ACT_MON_SAT_EN (in kf_event_counter) makes the live counters saturate.
module kf_activity_monitor
  import kf_activity_monitor_pkg::*;
#(
  parameter int N_CH      = KF_ACT_N_CH_DEFAULT,
  parameter int CNT_W     = 32,
  parameter int WIN_LOG2  = 20,
  parameter int EMA_SHIFT = 3,
  parameter int HIST_LEN  = 16,
  parameter int DREAM_OVH = KF_DREAM_POWER_OVH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  kf_activity_monitor_if.slave   bus,
  input  logic                   busy_in,
  input  logic                   dream_active,
  input  logic                   clr,
  output logic [15:0]            activity_level,
  output logic [7:0]             power_hint,
  output logic [15:0]            entropy,
  output logic                   window_tick
);

  localparam int HIT_W = $clog2(N_CH + 1);
  localparam int HL_W  = $clog2(HIST_LEN);
  localparam int NCNT  = N_CH + 2;
  localparam int AW    = $clog2(N_CH + 2);

  logic [N_CH-1:0]     hit;
  logic [HIT_W-1:0]    n_hit;
  logic [CNT_W-1:0]    live_cnt [NCNT];
  logic [CNT_W-1:0]    shadow_q [NCNT];
  logic [CNT_W-1:0]    shadow_d [NCNT];
  logic                snap_valid_q, snap_valid_d;
  logic [WIN_LOG2-1:0] win_ctr_q, win_ctr_d;
  logic [7:0]          win_evt_q, win_evt_d;
  logic [15:0]         acc_q, acc_d;
  logic [7:0]          power_hint_q, power_hint_d;
  logic [HIST_LEN-1:0] hist_q, hist_d;
  logic [15:0]         entropy_q, entropy_d;
  logic                window_tick_q, window_tick_d;
  logic [HIST_LEN-1:0] hist_sh;
  logic [HL_W-1:0]     trans_cnt;
  logic [8:0]          win_sum;
  logic [7:0]          win_sat;
  logic                win_close;

  function automatic logic [7:0] sat_u8(input logic [15:0] v);
    return (v > 16'd255) ? 8'hFF : v[7:0];
  endfunction

  // The result never exceeds max(acc, s), so 16 bits cannot overflow.
  function automatic logic [15:0] ema_step(input logic [15:0] acc,
                                           input logic [15:0] s);
    return acc - (acc >> EMA_SHIFT) + (s >> EMA_SHIFT);
  endfunction

  assign hit = bus.ev_valid & bus.ev_ready;

  // Number of channels completing a handshake this cycle.
  always_comb begin
    n_hit = '0;
    for (int i = 0; i < N_CH; i++) n_hit = n_hit + HIT_W'(hit[i]);
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    kf_event_counter #(.W(CNT_W), .INC_W(1)) u_ch_cnt (
      .clk(clk), .rst_n(rst_n), .inc(hit[g]), .clr_load(clr), .cnt(live_cnt[g])
    );
  end

  kf_event_counter #(.W(CNT_W), .INC_W(HIT_W)) u_total_cnt (
    .clk(clk), .rst_n(rst_n), .inc(n_hit), .clr_load(clr), .cnt(live_cnt[N_CH])
  );

  kf_event_counter #(.W(CNT_W), .INC_W(1)) u_busy_cnt (
    .clk(clk), .rst_n(rst_n), .inc(busy_in), .clr_load(clr), .cnt(live_cnt[N_CH+1])
  );

  // Shift in this cycle's activity bit and count adjacent-bit transitions.
  always_comb begin
    hist_sh   = {hist_q[HIST_LEN-2:0], |hit};
    trans_cnt = '0;
    for (int i = 0; i < HIST_LEN - 1; i++)
      trans_cnt = trans_cnt + HL_W'(hist_sh[i] ^ hist_sh[i+1]);
  end

  // Next-state for snapshot, window/EMA, power hint and entropy.
  always_comb begin
    win_close     = &win_ctr_q;
    win_sum       = 9'(win_evt_q) + 9'(n_hit);
    win_sat       = sat_u8(16'(win_sum));
    shadow_d      = shadow_q;
    if (bus.snap_req) shadow_d = live_cnt;
    snap_valid_d  = bus.snap_req;
    power_hint_d  = sat_u8(16'(acc_q[15:8]) + (dream_active ? 16'(DREAM_OVH) : 16'd0));
    win_ctr_d     = win_ctr_q + WIN_LOG2'(1);
    win_evt_d     = win_sat;
    acc_d         = acc_q;
    window_tick_d = 1'b0;
    hist_d        = hist_sh;
    entropy_d     = 16'(trans_cnt) << (16 - HL_W);
    if (clr) begin
      win_ctr_d = '0;
      win_evt_d = '0;
      acc_d     = '0;
      hist_d    = '0;
      entropy_d = '0;
    end else if (win_close) begin
      acc_d         = ema_step(acc_q, {win_sat, 8'h00});
      win_evt_d     = '0;
      window_tick_d = 1'b1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q      <= '{default: '0};
      snap_valid_q  <= 1'b0;
      win_ctr_q     <= '0;
      win_evt_q     <= '0;
      acc_q         <= '0;
      power_hint_q  <= '0;
      hist_q        <= '0;
      entropy_q     <= '0;
      window_tick_q <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      snap_valid_q  <= snap_valid_d;
      win_ctr_q     <= win_ctr_d;
      win_evt_q     <= win_evt_d;
      acc_q         <= acc_d;
      power_hint_q  <= power_hint_d;
      hist_q        <= hist_d;
      entropy_q     <= entropy_d;
      window_tick_q <= window_tick_d;
    end
  end

  // Zero-latency shadow readout; unmapped addresses read as zero.
  always_comb begin
    bus.rd_data = '0;
    for (int i = 0; i < NCNT; i++)
      if (bus.rd_addr == AW'(i)) bus.rd_data = shadow_q[i];
  end

  assign bus.snap_valid = snap_valid_q;
  assign activity_level = acc_q;
  assign power_hint     = power_hint_q;
  assign entropy        = entropy_q;
  assign window_tick    = window_tick_q;

endmodule

// File: tb/tb_kf_activity_monitor.sv
// Self-checking bench for kf_activity_monitor: directed scenarios plus a
// randomized run against a behavioural model of counts, windows, EMA,
// power hint, entropy and snapshots.
module tb_kf_activity_monitor;
  import kf_activity_monitor_pkg::*;

  localparam int N_CH = 5, CNT_W = 16, WIN_LOG2 = 6, EMA_SHIFT = 3;
  localparam int HIST_LEN = 16, DREAM_OVH = 32;
  localparam int WIN_LEN = 1 << WIN_LOG2;
  localparam int MASK = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic busy_in, dream_active, clr;
  logic [15:0] activity_level, entropy;
  logic [7:0]  power_hint;
  logic        window_tick;

  logic s_busy, s_dream, s_clr;
  logic [15:0] s_act, s_ent;
  logic [7:0]  s_ph;
  logic        s_tick;

  kf_activity_monitor_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();
  kf_activity_monitor_if #(.N_CH(N_CH), .CNT_W(4))     s_bus ();

  kf_activity_monitor #(
    .N_CH(N_CH), .CNT_W(CNT_W), .WIN_LOG2(WIN_LOG2), .EMA_SHIFT(EMA_SHIFT),
    .HIST_LEN(HIST_LEN), .DREAM_OVH(DREAM_OVH)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .busy_in(busy_in),
    .dream_active(dream_active), .clr(clr), .activity_level(activity_level),
    .power_hint(power_hint), .entropy(entropy), .window_tick(window_tick)
  );

  kf_activity_monitor #(.N_CH(N_CH), .CNT_W(4), .WIN_LOG2(4)) u_small (
    .clk(clk), .rst_n(rst_n), .bus(s_bus.slave), .busy_in(s_busy),
    .dream_active(s_dream), .clr(s_clr), .activity_level(s_act),
    .power_hint(s_ph), .entropy(s_ent), .window_tick(s_tick)
  );

  always #5 clk = ~clk;

  int total_cnt = 0, bad_cnt = 0;

  // Behavioural model state: index 0..4 channels, 5 total, 6 busy.
  int m_cnt [7];
  int m_sh  [7];
  int m_winpos, m_winevt, m_act, m_ph, m_ent;
  bit m_tick, m_snapv;
  bit m_hq [$];

  task automatic model_reset();
    for (int i = 0; i < 7; i++) begin m_cnt[i] = 0; m_sh[i] = 0; end
    m_winpos = 0; m_winevt = 0; m_act = 0; m_ph = 0; m_ent = 0;
    m_tick = 0; m_snapv = 0; m_hq.delete();
  endtask

  // Drive one cycle of inputs, wait for the edge, advance the model.
  task automatic step(input logic [4:0] v, input logic [4:0] r, input logic b,
                      input logic d, input logic c, input logic s);
    logic [4:0] hit;
    int nh, ph_new, sum, samp, tr;
    int pre [7];
    bus.ev_valid = v; bus.ev_ready = r; busy_in = b; dream_active = d;
    clr = c; bus.snap_req = s;
    hit = v & r;
    nh = $countones(hit);
    for (int i = 0; i < 7; i++) pre[i] = m_cnt[i];
    ph_new = (m_act >> 8) + (d ? DREAM_OVH : 0);
    if (ph_new > 255) ph_new = 255;
    @(posedge clk); #1;
    m_ph = ph_new;
    m_snapv = s;
    if (s) for (int i = 0; i < 7; i++) m_sh[i] = pre[i];
    if (c) begin
      for (int i = 0; i < 5; i++) m_cnt[i] = int'(hit[i]);
      m_cnt[5] = nh; m_cnt[6] = int'(b);
      m_winpos = 0; m_winevt = 0; m_act = 0; m_tick = 0; m_ent = 0;
      m_hq.delete();
    end else begin
      for (int i = 0; i < 5; i++) m_cnt[i] = (m_cnt[i] + int'(hit[i])) & MASK;
      m_cnt[5] = (m_cnt[5] + nh) & MASK;
      m_cnt[6] = (m_cnt[6] + int'(b)) & MASK;
      sum = m_winevt + nh;
      if (sum > 255) sum = 255;
      if (m_winpos == WIN_LEN - 1) begin
        samp = sum * 256;
        m_act = m_act - (m_act >> EMA_SHIFT) + (samp >> EMA_SHIFT);
        m_winevt = 0; m_tick = 1; m_winpos = 0;
      end else begin
        m_winevt = sum; m_tick = 0; m_winpos++;
      end
      m_hq.push_back(nh != 0);
      if (m_hq.size() > HIST_LEN) void'(m_hq.pop_front());
      tr = 0;
      for (int k = 0; k < HIST_LEN - 1; k++) begin
        bit a0, a1;
        a0 = (k < m_hq.size()) ? m_hq[m_hq.size()-1-k] : 1'b0;
        a1 = (k + 1 < m_hq.size()) ? m_hq[m_hq.size()-2-k] : 1'b0;
        if (a0 != a1) tr++;
      end
      m_ent = tr << (16 - $clog2(HIST_LEN));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (activity_level !== 16'd0) begin bad_cnt++; $display("FAIL reset_act got=%0d want=0", activity_level); end
    total_cnt++; if (power_hint !== 8'd0) begin bad_cnt++; $display("FAIL reset_power got=%0d want=0", power_hint); end
    total_cnt++; if (entropy !== 16'd0) begin bad_cnt++; $display("FAIL reset_entropy got=%0d want=0", entropy); end
    total_cnt++; if (window_tick !== 1'b0) begin bad_cnt++; $display("FAIL reset_tick got=%0b want=0", window_tick); end
    total_cnt++; if (bus.snap_valid !== 1'b0) begin bad_cnt++; $display("FAIL reset_snapv got=%0b want=0", bus.snap_valid); end
    for (int a = 0; a < 8; a++) begin
      bus.rd_addr = 3'(a); #1;
      total_cnt++; if (bus.rd_data !== 16'd0) begin bad_cnt++; $display("FAIL reset_shadow%0d got=%0d want=0", a, bus.rd_data); end
    end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_channel();
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(5'b00100, 5'b00100, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    total_cnt++; if (bus.snap_valid !== 1'b1) begin bad_cnt++; $display("FAIL single_snapv got=%0b want=1", bus.snap_valid); end
    bus.rd_addr = 3'(KF_ACT_CH_SOUTH); #1;
    total_cnt++; if (bus.rd_data !== 16'd10) begin bad_cnt++; $display("FAIL single_ch2 got=%0d want=10", bus.rd_data); end
    bus.rd_addr = ACT_RD_TOTAL; #1;
    total_cnt++; if (bus.rd_data !== 16'd10) begin bad_cnt++; $display("FAIL single_total got=%0d want=10", bus.rd_data); end
    bus.rd_addr = ACT_RD_CH_LOCAL; #1;
    total_cnt++; if (bus.rd_data !== 16'd0) begin bad_cnt++; $display("FAIL single_ch0 got=%0d want=0", bus.rd_data); end
    bus.rd_addr = ACT_RD_BUSY; #1;
    total_cnt++; if (bus.rd_data !== 16'd10) begin bad_cnt++; $display("FAIL single_busy got=%0d want=10", bus.rd_data); end
    idle(1);
    total_cnt++; if (bus.snap_valid !== 1'b0) begin bad_cnt++; $display("FAIL single_snapv_drop got=%0b want=0", bus.snap_valid); end
  endtask

  task automatic test_simultaneous();
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(5'h1F, 5'h1F, 1'b0, 1'b0, 1'b0, 1'b0);
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int a = 0; a < 5; a++) begin
      bus.rd_addr = 3'(a); #1;
      total_cnt++; if (bus.rd_data !== 16'd3) begin bad_cnt++; $display("FAIL simul_ch%0d got=%0d want=3", a, bus.rd_data); end
    end
    bus.rd_addr = ACT_RD_TOTAL; #1;
    total_cnt++; if (bus.rd_data !== 16'd15) begin bad_cnt++; $display("FAIL simul_total got=%0d want=15", bus.rd_data); end
    bus.rd_addr = 3'd7; #1;
    total_cnt++; if (bus.rd_data !== 16'd0) begin bad_cnt++; $display("FAIL simul_unmapped got=%0d want=0", bus.rd_data); end
  endtask

  task automatic test_back_to_back();
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.rd_addr = 3'(KF_ACT_CH_NORTH);
    for (int i = 0; i < 2; i++) begin
      step(5'b00010, 5'b00010, 1'b0, 1'b0, 1'b0, 1'b1);
      total_cnt++; if (bus.snap_valid !== 1'b1) begin bad_cnt++; $display("FAIL b2b_snapv%0d got=%0b want=1", i, bus.snap_valid); end
      total_cnt++; if (bus.rd_data !== 16'(i)) begin bad_cnt++; $display("FAIL b2b_shadow%0d got=%0d want=%0d", i, bus.rd_data, i); end
    end
    step(5'b00010, 5'b00010, 1'b0, 1'b0, 1'b0, 1'b0);
    total_cnt++; if (bus.snap_valid !== 1'b0) begin bad_cnt++; $display("FAIL b2b_snapv_end got=%0b want=0", bus.snap_valid); end
    total_cnt++; if (bus.rd_data !== 16'd1) begin bad_cnt++; $display("FAIL b2b_hold got=%0d want=1", bus.rd_data); end
  endtask

  task automatic test_read_and_clear();
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(5'b00001, 5'b00001, 1'b0, 1'b0, 1'b0, 1'b0);
    step(5'b00001, 5'b00001, 1'b0, 1'b0, 1'b1, 1'b1);
    bus.rd_addr = ACT_RD_CH_LOCAL; #1;
    total_cnt++; if (bus.rd_data !== 16'd7) begin bad_cnt++; $display("FAIL rac_shadow got=%0d want=7", bus.rd_data); end
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    total_cnt++; if (bus.rd_data !== 16'd1) begin bad_cnt++; $display("FAIL rac_live_ch0 got=%0d want=1", bus.rd_data); end
    bus.rd_addr = ACT_RD_TOTAL; #1;
    total_cnt++; if (bus.rd_data !== 16'd1) begin bad_cnt++; $display("FAIL rac_live_total got=%0d want=1", bus.rd_data); end
  endtask

  task automatic test_entropy();
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    total_cnt++; if (entropy !== 16'd0) begin bad_cnt++; $display("FAIL ent_clr got=%0d want=0", entropy); end
    for (int i = 0; i < 16; i++) begin
      step((i % 2 == 0) ? 5'b01000 : 5'b0, 5'b01000, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 7) begin
        total_cnt++; if (entropy !== 16'(m_ent)) begin bad_cnt++; $display("FAIL ent_mid got=%0d want=%0d", entropy, m_ent); end
      end
    end
    total_cnt++; if (entropy !== 16'd61440) begin bad_cnt++; $display("FAIL ent_alt got=%0d want=61440", entropy); end
  endtask

  task automatic test_ema_steady();
    int prev;
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    prev = 0;
    for (int w = 0; w < 8; w++) begin
      for (int c = 0; c < WIN_LEN; c++) begin
        step((c < 20) ? 5'h1F : 5'h0, 5'h1F, 1'b0, 1'b0, 1'b0, 1'b0);
        if (c == WIN_LEN - 2) begin
          total_cnt++; if (window_tick !== 1'b0) begin bad_cnt++; $display("FAIL ema_tick_early w%0d got=%0b want=0", w, window_tick); end
        end
        if (c == 31) begin
          total_cnt++; if (activity_level !== 16'(prev)) begin bad_cnt++; $display("FAIL ema_hold w%0d got=%0d want=%0d", w, activity_level, prev); end
        end
      end
      total_cnt++; if (window_tick !== 1'b1) begin bad_cnt++; $display("FAIL ema_tick w%0d got=%0b want=1", w, window_tick); end
      total_cnt++; if (activity_level !== 16'(m_act)) begin bad_cnt++; $display("FAIL ema_level w%0d got=%0d want=%0d", w, activity_level, m_act); end
      total_cnt++; if (!(int'(activity_level) > prev && activity_level <= 16'd25600)) begin bad_cnt++; $display("FAIL ema_mono w%0d got=%0d prev=%0d want rising <=25600", w, activity_level, prev); end
      prev = int'(activity_level);
    end
  endtask

  task automatic test_ema_clamp_power();
    for (int w = 0; w < 24; w++) begin
      for (int c = 0; c < WIN_LEN; c++)
        step((c < 60) ? 5'h1F : 5'h0, 5'h1F, 1'b0, 1'b0, 1'b0, 1'b0);
      total_cnt++; if (activity_level !== 16'(m_act)) begin bad_cnt++; $display("FAIL clamp_level w%0d got=%0d want=%0d", w, activity_level, m_act); end
    end
    total_cnt++; if (activity_level[15:8] < 8'd240) begin bad_cnt++; $display("FAIL clamp_high got=%0d want>=61440", activity_level); end
    step(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    total_cnt++; if (power_hint !== 8'd255) begin bad_cnt++; $display("FAIL power_dream got=%0d want=255", power_hint); end
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    total_cnt++; if (power_hint !== 8'(m_ph)) begin bad_cnt++; $display("FAIL power_plain got=%0d want=%0d", power_hint, m_ph); end
  endtask

  task automatic test_reset_mid_window();
    for (int i = 0; i < 10; i++) step(5'h1F, 5'h1F, 1'b1, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0; #1;
    bus.rd_addr = ACT_RD_TOTAL; #1;
    total_cnt++; if (activity_level !== 16'd0) begin bad_cnt++; $display("FAIL rstmid_act got=%0d want=0", activity_level); end
    total_cnt++; if (bus.rd_data !== 16'd0) begin bad_cnt++; $display("FAIL rstmid_shadow got=%0d want=0", bus.rd_data); end
    total_cnt++; if (entropy !== 16'd0) begin bad_cnt++; $display("FAIL rstmid_ent got=%0d want=0", entropy); end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < WIN_LEN; i++) step(5'b00001, 5'b00001, 1'b0, 1'b0, 1'b0, 1'b0);
    total_cnt++; if (window_tick !== 1'b1) begin bad_cnt++; $display("FAIL rstmid_tick got=%0b want=1", window_tick); end
    total_cnt++; if (activity_level !== 16'(m_act)) begin bad_cnt++; $display("FAIL rstmid_level got=%0d want=%0d", activity_level, m_act); end
  endtask

  task automatic test_random();
    logic [4:0] v, r;
    logic [2:0] a;
    for (int i = 0; i < 500; i++) begin
      v = 5'($urandom); r = 5'($urandom | $urandom);
      step(v, r, 1'($urandom), 1'($urandom), ($urandom_range(0, 79) == 0),
           ($urandom_range(0, 4) == 0));
      total_cnt++; if (activity_level !== 16'(m_act)) begin bad_cnt++; $display("FAIL rnd_act c%0d got=%0d want=%0d", i, activity_level, m_act); end
      total_cnt++; if (power_hint !== 8'(m_ph)) begin bad_cnt++; $display("FAIL rnd_power c%0d got=%0d want=%0d", i, power_hint, m_ph); end
      total_cnt++; if (entropy !== 16'(m_ent)) begin bad_cnt++; $display("FAIL rnd_ent c%0d got=%0d want=%0d", i, entropy, m_ent); end
      total_cnt++; if (window_tick !== m_tick) begin bad_cnt++; $display("FAIL rnd_tick c%0d got=%0b want=%0b", i, window_tick, m_tick); end
      total_cnt++; if (bus.snap_valid !== m_snapv) begin bad_cnt++; $display("FAIL rnd_snapv c%0d got=%0b want=%0b", i, bus.snap_valid, m_snapv); end
      a = 3'($urandom);
      bus.rd_addr = a; #1;
      total_cnt++; if (bus.rd_data !== ((a < 3'd7) ? 16'(m_sh[a]) : 16'd0)) begin bad_cnt++; $display("FAIL rnd_rd c%0d addr=%0d got=%0d want=%0d", i, a, bus.rd_data, (a < 3'd7) ? m_sh[a] : 0); end
    end
  endtask

  task automatic test_saturation();
    int want;
`ifdef KF_ACT_MON_SAT_EN
    want = 15;
`else
    want = 4;
`endif
    s_bus.ev_valid = 5'b00001; s_bus.ev_ready = 5'b00001;
    idle(20);
    s_bus.ev_valid = 5'b0; s_bus.snap_req = 1'b1;
    idle(1);
    s_bus.snap_req = 1'b0;
    s_bus.rd_addr = 3'd0; #1;
    total_cnt++; if (s_bus.rd_data !== 4'(want)) begin bad_cnt++; $display("FAIL sat_ch0 got=%0d want=%0d", s_bus.rd_data, want); end
    s_bus.rd_addr = 3'd5; #1;
    total_cnt++; if (s_bus.rd_data !== 4'(want)) begin bad_cnt++; $display("FAIL sat_total got=%0d want=%0d", s_bus.rd_data, want); end
  endtask

  initial begin
    bus.ev_valid = '0; bus.ev_ready = '0; bus.snap_req = 1'b0; bus.rd_addr = '0;
    s_bus.ev_valid = '0; s_bus.ev_ready = '0; s_bus.snap_req = 1'b0; s_bus.rd_addr = '0;
    busy_in = 1'b0; dream_active = 1'b0; clr = 1'b0;
    s_busy = 1'b0; s_dream = 1'b0; s_clr = 1'b0;
    model_reset();
    test_reset();
    test_single_channel();
    test_simultaneous();
    test_back_to_back();
    test_read_and_clear();
    test_entropy();
    test_ema_steady();
    test_ema_clamp_power();
    test_reset_mid_window();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "time limit reached");
  end

endmodule
